flash_boot_loader: RTL



---
 rtl/flash_boot_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/flash_boot_loader.sv
// Boot-time SPI flash reader: streams an image out of SPI flash (mode 0,
// READ 0x03) into instruction memory, then releases the core via boot_done.
module flash_boot_loader #(
    parameter int          CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          NUM_WORDS  = 1024,
    parameter int          IMEM_AW    = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_boot_en,
    output logic               o_flash_sclk,
    output logic               o_flash_cs_n,
    output logic               o_flash_mosi,
    input  logic               i_flash_miso,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [31:0]        o_imem_wdata,
    output logic               o_boot_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CS_HOLD,
        S_DONE
    } state_t;

    localparam logic [7:0]       LP_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [IMEM_AW:0] LP_WORDS    = (IMEM_AW + 1)'(NUM_WORDS);
    localparam logic [7:0]       LP_CMD_READ = 8'h03;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cnt;
    logic               r_sclk;
    logic               r_cs_n;
    logic               r_done;
    logic               r_we;
    logic [4:0]         r_bit;
    logic [IMEM_AW:0]   r_word;
    logic [31:0]        r_tx;
    logic [30:0]        r_rx;
    logic [IMEM_AW-1:0] r_addr;
    logic [31:0]        r_wdata;

    logic               w_cnt_last;
    logic               w_shifting;
    logic               w_timed;
    logic               w_rise;
    logic               w_fall;
    logic               w_word_end;
    logic               w_load_tx;
    logic               w_cs_active;
    logic [31:0]        w_word;

    assign w_cnt_last  = (r_cnt == LP_DIV_LAST);
    assign w_shifting  = (r_state == S_CMD) || (r_state == S_ADDR) ||
                         (r_state == S_DATA);
    assign w_timed     = w_shifting || (r_state == S_CS_SETUP) ||
                         (r_state == S_CS_HOLD);
    assign w_rise      = w_shifting && !r_sclk && w_cnt_last;
    assign w_fall      = w_shifting && r_sclk && w_cnt_last;
    assign w_word      = {r_rx, i_flash_miso};
    assign w_word_end  = w_rise && (r_state == S_DATA) && (r_bit == 5'd31);
    assign w_load_tx   = (r_state == S_IDLE) && (w_next == S_CS_SETUP);
    assign w_cs_active = (w_next == S_CS_SETUP) || (w_next == S_CMD) ||
                         (w_next == S_ADDR) || (w_next == S_DATA);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a bit ends on the clk edge where sclk falls
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     w_next = i_boot_en ? S_CS_SETUP : S_DONE;
            S_CS_SETUP: if (w_cnt_last) w_next = S_CMD;
            S_CMD:      if (w_fall && (r_bit == 5'd7)) w_next = S_ADDR;
            S_ADDR:     if (w_fall && (r_bit == 5'd31)) w_next = S_DATA;
            S_DATA:     if (w_fall && (r_word == LP_WORDS)) w_next = S_CS_HOLD;
            S_CS_HOLD:  if (w_cnt_last) w_next = S_DONE;
            S_DONE:     w_next = S_DONE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Phase counter: times every CLK_DIV-cycle half period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
        end else if (w_timed && !w_cnt_last) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    // SPI clock: low half then high half per bit, idles low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk <= 1'b0;
        end else if (w_rise) begin
            r_sclk <= 1'b1;
        end else if (w_fall || !w_shifting) begin
            r_sclk <= 1'b0;
        end
    end

    // Chip select and sticky boot_done follow the upcoming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_cs_n <= !w_cs_active;
            r_done <= (w_next == S_DONE);
        end
    end

    // Bit counter advances at the end of every bit, wrapping per word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit <= 5'd0;
        end else if (w_fall) begin
            r_bit <= r_bit + 5'd1;
        end
    end

    // Command/address shifter; zeros shifted in keep MOSI low during data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx <= 32'd0;
        end else if (w_load_tx) begin
            r_tx <= {LP_CMD_READ, FLASH_BASE};
        end else if (w_fall) begin
            r_tx <= {r_tx[30:0], 1'b0};
        end
    end

    // Receive shifter samples MISO where sclk rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx <= 31'd0;
        end else if (w_rise && (r_state == S_DATA)) begin
            r_rx <= w_word[30:0];
        end
    end

    // Word write: byte-swap the MSB-first stream into a little-endian word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_word  <= '0;
        end else begin
            r_we <= w_word_end;
            if (w_word_end) begin
                r_addr  <= r_word[IMEM_AW-1:0];
                r_wdata <= {w_word[7:0], w_word[15:8],
                            w_word[23:16], w_word[31:24]};
                r_word  <= r_word + 1'b1;
            end
        end
    end

    assign o_flash_sclk = r_sclk;
    assign o_flash_cs_n = r_cs_n;
    assign o_flash_mosi = r_tx[31];
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_boot_done  = r_done;

endmodule
